// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared types for the front-panel button event controller.
//   ev_code_t  : event codes carried on the event channel (3 bits)
//   btn_fsm_t  : per-button gesture FSM states
//   cnt_bits() : width of a counter that must reach (max_count-1), minimum 1
// -----------------------------------------------------------------------------
package button_event_pkg;

    typedef enum logic [2:0] {
        EV_PRESS        = 3'd0,
        EV_CLICK        = 3'd1,
        EV_LONG         = 3'd2,
        EV_REPEAT       = 3'd3,
        EV_LONG_RELEASE = 3'd4
    } ev_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } btn_fsm_t;

    function automatic int cnt_bits(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/button_gesture.sv
// -----------------------------------------------------------------------------
// button_gesture
// One button's gesture FSM. Turns the debounced level into PRESS, CLICK,
// LONG, REPEAT and LONG_RELEASE posts. The post strobe and code are
// registered together with the state transition that produced them.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous, active-high reset (FSM -> IDLE)
//   i_db    in  debounced level (1 = pressed)
//   i_db_q  in  i_db delayed one cycle, for rising-edge detection
//   o_post  out one-cycle strobe: an event is posted
//   o_code  out code of the posted event (valid with o_post)
// -----------------------------------------------------------------------------
module button_gesture
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 13500000,
    parameter int REPEAT_CYCLES = 2700000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_db,
    input  logic     i_db_q,
    output logic     o_post,
    output ev_code_t o_code
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = cnt_bits(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_fsm_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_post;
    ev_code_t         r_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_post  <= 1'b0;
            r_code  <= EV_PRESS;
        end else begin
            r_post <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_db && !i_db_q) begin
                        r_post  <= 1'b1;
                        r_code  <= EV_PRESS;
                        r_cnt   <= '0;
                        r_state <= ST_HELD;
                    end
                end
                // Release is tested before the terminal count so a release
                // on the terminal cycle still reports CLICK / LONG_RELEASE.
                ST_HELD: begin
                    if (!i_db) begin
                        r_post  <= 1'b1;
                        r_code  <= EV_CLICK;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == LONG_LAST) begin
                        r_post  <= 1'b1;
                        r_code  <= EV_LONG;
                        r_cnt   <= '0;
                        r_state <= ST_LONG;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!i_db) begin
                        r_post  <= 1'b1;
                        r_code  <= EV_LONG_RELEASE;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == REPEAT_LAST) begin
                        r_post <= 1'b1;
                        r_code <= EV_REPEAT;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_post = r_post;
    assign o_code = r_code;

endmodule

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Level debouncer: o_level follows i_level only after i_level has held the
// opposite value for DEBOUNCE_TIME consecutive cycles. Any return to the
// current o_level restarts the count.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous, active-high reset (o_level -> 0)
//   i_level  in  synchronised, polarity-normalised level
//   o_level  out debounced level
// -----------------------------------------------------------------------------
module debounce
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_TIME = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_level
);

    localparam int CNT_W = cnt_bits(DEBOUNCE_TIME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TIME - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_level == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= i_level;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
// Front-panel button event controller. Each raw pin is synchronised,
// polarity-normalised, debounced and fed to its own gesture FSM. Posted
// events wait in a one-entry pending slot per button; a round-robin arbiter
// moves them into a single valid/ready output register.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous, active-high reset
//   btn_raw_i    in  [NUM_BUTTONS] raw, unsynchronised button pins
//   ev_valid_o   out event available
//   ev_ready_i   in  consumer accepts the event
//   ev_button_o  out index of the button that produced the event
//   ev_code_o    out event code (ev_code_t)
//   btn_state_o  out [NUM_BUTTONS] debounced level, 1 = pressed
//   overflow_o   out [NUM_BUTTONS] sticky lost-event flag, cleared by rst only
// -----------------------------------------------------------------------------
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int                     NUM_BUTTONS   = 4,
    parameter int                     DEBOUNCE_TIME = 100000,
    parameter int                     LONG_CYCLES   = 13500000,
    parameter int                     REPEAT_CYCLES = 2700000,
    parameter logic [NUM_BUTTONS-1:0] ACTIVE_LOW    = '1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_BUTTONS-1:0]               btn_raw_i,
    output logic                                 ev_valid_o,
    input  logic                                 ev_ready_i,
    output logic [cnt_bits(NUM_BUTTONS)-1:0]     ev_button_o,
    output logic [2:0]                           ev_code_o,
    output logic [NUM_BUTTONS-1:0]               btn_state_o,
    output logic [NUM_BUTTONS-1:0]               overflow_o
);

    localparam int BTN_W = cnt_bits(NUM_BUTTONS);

    // Input path
    logic [NUM_BUTTONS-1:0] r_sync1, r_sync2, r_db_q;
    logic [NUM_BUTTONS-1:0] w_level, w_db, w_post;
    ev_code_t               w_code [NUM_BUTTONS];

    // Pending slots
    logic [NUM_BUTTONS-1:0] r_full;
    ev_code_t               r_code [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] r_overflow;

    // Arbiter / output register
    logic [BTN_W-1:0]       r_last;
    logic [BTN_W-1:0]       w_sel;
    logic                   w_found;
    logic                   w_load;
    logic [NUM_BUTTONS-1:0] w_grant;
    logic                   r_ev_valid;
    logic [BTN_W-1:0]       r_ev_button;
    ev_code_t               r_ev_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db_q  <= '0;
        end else begin
            r_sync1 <= btn_raw_i;
            r_sync2 <= r_sync1;
            r_db_q  <= w_db;
        end
    end

    assign w_level = r_sync2 ^ ACTIVE_LOW;

    for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_btn
        debounce #(
            .DEBOUNCE_TIME (DEBOUNCE_TIME)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_level (w_level[k]),
            .o_level (w_db[k])
        );

        button_gesture #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_gesture (
            .clk    (clk),
            .rst    (rst),
            .i_db   (w_db[k]),
            .i_db_q (r_db_q[k]),
            .o_post (w_post[k]),
            .o_code (w_code[k])
        );
    end

    function automatic int wrap_idx(input int base, input int off);
        int sum;
        sum = base + off;
        return (sum >= NUM_BUTTONS) ? sum - NUM_BUTTONS : sum;
    endfunction

    assign w_load = !r_ev_valid || ev_ready_i;

    // Round-robin search starting just after the last granted button.
    // NOTE: every signal written here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_grant = '0;
        for (int i = 1; i <= NUM_BUTTONS; i++) begin
            if (!w_found && r_full[wrap_idx(int'(r_last), i)]) begin
                w_found = 1'b1;
                w_sel   = BTN_W'(wrap_idx(int'(r_last), i));
            end
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            w_grant[i] = w_load && w_found && (w_sel == BTN_W'(i));
        end
    end

    // A post that meets a same-cycle grant refills the slot: the grant
    // carries the old entry out, so nothing is lost and no overflow is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= '0;
            r_overflow <= '0;
            // NOTE: the slot codes are a handful of flops, not a RAM, so they
            // are reset along with everything else for a clean known state.
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                r_code[k] <= EV_PRESS;
            end
        end else begin
            for (int k = 0; k < NUM_BUTTONS; k++) begin
                if (w_post[k]) begin
                    if (r_full[k] && !w_grant[k]) begin
                        if (w_code[k] != EV_REPEAT) begin
                            r_code[k]     <= w_code[k];
                            r_overflow[k] <= 1'b1;
                        end
                    end else begin
                        r_code[k] <= w_code[k];
                        r_full[k] <= 1'b1;
                    end
                end else if (w_grant[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_valid  <= 1'b0;
            r_ev_button <= '0;
            r_ev_code   <= EV_PRESS;
            r_last      <= BTN_W'(NUM_BUTTONS - 1);
        end else if (w_load) begin
            if (w_found) begin
                r_ev_valid  <= 1'b1;
                r_ev_button <= w_sel;
                r_ev_code   <= r_code[w_sel];
                r_last      <= w_sel;
            end else begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign ev_valid_o  = r_ev_valid;
    assign ev_button_o = r_ev_button;
    assign ev_code_o   = r_ev_code;
    assign btn_state_o = w_db;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_button_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_event_ctrl
// Scoreboard bench: expected events (button, code, optional spacing in cycles
// from the previous accepted event) are queued as stimulus is driven and are
// popped by a monitor whenever the DUT hands off an event.
// -----------------------------------------------------------------------------
module tb_button_event_ctrl;
    import button_event_pkg::*;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic          ev_valid;
    logic          ev_ready;
    logic [1:0]    ev_button;
    logic [2:0]    ev_code;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] overflow;

    typedef struct {
        int btn;
        int code;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   last_acc = 0;
    int   m_last   = NB - 1;

    button_event_ctrl #(
        .NUM_BUTTONS   (NB),
        .DEBOUNCE_TIME (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (8),
        .ACTIVE_LOW    (4'b0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw_i   (btn_raw),
        .ev_valid_o  (ev_valid),
        .ev_ready_i  (ev_ready),
        .ev_button_o (ev_button),
        .ev_code_o   (ev_code),
        .btn_state_o (btn_state),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int b, input ev_code_t c, input int gap);
        exp_t e;
        e.btn  = b;
        e.code = int'(c);
        e.gap  = gap;
        sb.push_back(e);
        m_last = b;
    endtask

    // All buttons post together: expected order starts after the last grant.
    task automatic push_group(input ev_code_t c);
        int start;
        start = m_last;
        for (int i = 1; i <= NB; i++) begin
            push_ev((start + i) % NB, c, (i == 1) ? -1 : 1);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick(1);
        check({"drain_", tag}, sb.size(), 0);
    endtask

    // Monitor: outputs sampled on the falling edge, where the values that
    // the next rising edge will transfer are stable.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (!rst && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                check($sformatf("unexpected_ev_btn%0d_code%0d", ev_button, ev_code), sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("ev_button", int'(ev_button), e.btn);
                check("ev_code", int'(ev_code), e.code);
                if (e.gap > 0) check("ev_gap", cyc - last_acc, e.gap);
            end
            last_acc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        btn_raw  = '0;
        ev_ready = 1'b1;
        tick(3);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_button", int'(ev_button), 0);
        check("rst_code", int'(ev_code), 0);
        check("rst_state", int'(btn_state), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        tick(2);

        // Fairness from reset: button 0 wins first.
        push_group(EV_PRESS);
        push_group(EV_CLICK);
        btn_raw = 4'hF;
        tick(10);
        btn_raw = 4'h0;
        wait_drain("fair1", 60);

        // Short click preceded by two 2-cycle glitches.
        push_ev(0, EV_PRESS, -1);
        push_ev(0, EV_CLICK, 15);
        btn_raw[0] = 1'b1; tick(2);
        btn_raw[0] = 1'b0; tick(3);
        btn_raw[0] = 1'b1; tick(2);
        btn_raw[0] = 1'b0; tick(3);
        btn_raw[0] = 1'b1; tick(10);
        check("click_state", int'(btn_state), 1);
        tick(5);
        btn_raw[0] = 1'b0;
        wait_drain("click", 40);

        // Long hold on button 1 for 50 cycles.
        push_ev(1, EV_PRESS, -1);
        push_ev(1, EV_LONG, 20);
        push_ev(1, EV_REPEAT, 8);
        push_ev(1, EV_REPEAT, 8);
        push_ev(1, EV_REPEAT, 8);
        push_ev(1, EV_LONG_RELEASE, 6);
        btn_raw[1] = 1'b1;
        tick(50);
        btn_raw[1] = 1'b0;
        wait_drain("long", 60);

        // Fairness again: last grant was button 1, so order is 2,3,0,1.
        push_group(EV_PRESS);
        push_group(EV_CLICK);
        btn_raw = 4'hF;
        tick(10);
        btn_raw = 4'h0;
        wait_drain("fair2", 60);

        // Backpressure: PRESS parked in the output register, CLICK in the slot.
        ev_ready   = 1'b0;
        btn_raw[2] = 1'b1;
        tick(10);
        btn_raw[2] = 1'b0;
        tick(20);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", int'(ev_valid), 1);
            check("bp_button", int'(ev_button), 2);
            check("bp_code", int'(ev_code), int'(EV_PRESS));
            tick(1);
        end
        check("bp_overflow", int'(overflow), 0);
        push_ev(2, EV_PRESS, -1);
        push_ev(2, EV_CLICK, 1);
        ev_ready = 1'b1;
        wait_drain("bp", 20);

        // Overflow: press/release/press on button 3 with the channel stalled.
        ev_ready   = 1'b0;
        btn_raw[3] = 1'b1;
        tick(8);
        btn_raw[3] = 1'b0;
        tick(12);
        check("ovf_before", int'(overflow), 0);
        btn_raw[3] = 1'b1;
        tick(30);
        check("ovf_set", int'(overflow), 8);
        tick(10);
        btn_raw[3] = 1'b0;
        tick(15);
        check("ovf_after_repeat", int'(overflow), 8);
        check("ovf_hold_button", int'(ev_button), 3);
        check("ovf_hold_code", int'(ev_code), int'(EV_PRESS));
        push_ev(3, EV_PRESS, -1);
        push_ev(3, EV_LONG_RELEASE, 1);
        ev_ready = 1'b1;
        wait_drain("ovf", 20);

        // Reset while button 1 is in long-hold.
        push_ev(1, EV_PRESS, -1);
        push_ev(1, EV_LONG, 20);
        btn_raw[1] = 1'b1;
        wait_drain("pre_rst", 60);
        tick(2);
        rst = 1'b1;
        #2;
        check("mid_rst_valid", int'(ev_valid), 0);
        check("mid_rst_button", int'(ev_button), 0);
        check("mid_rst_code", int'(ev_code), 0);
        check("mid_rst_state", int'(btn_state), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_fsm", int'(dut.g_btn[1].u_gesture.r_state), int'(ST_IDLE));
        m_last = NB - 1;
        tick(3);
        rst = 1'b0;
        push_ev(1, EV_PRESS, -1);
        push_ev(1, EV_CLICK, -1);
        tick(10);
        check("post_rst_state", int'(btn_state), 2);
        tick(2);
        btn_raw[1] = 1'b0;
        wait_drain("post_rst", 40);

        tick(5);
        check("sb_final", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
